// File: rtl/apb_uart_pkg.sv
// Shared types and constants for the APB initiator that programs the UART subsystem.
// Holds the FSM state encoding, default bus widths, command/response payloads and register map.
package apb_uart_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  typedef struct packed {
    logic                          write;
    logic [DEFAULT_ADDR_WIDTH-1:0] addr;
    logic [DEFAULT_DATA_WIDTH-1:0] wdata;
  } apb_cmd_t;

  typedef struct packed {
    logic [DEFAULT_DATA_WIDTH-1:0] rdata;
    logic                          error;
    logic                          timeout;
  } apb_rsp_t;

  // UART slave register offsets
  localparam logic [DEFAULT_ADDR_WIDTH-1:0] UART_REG_TXDATA = 32'h0000_0000;
  localparam logic [DEFAULT_ADDR_WIDTH-1:0] UART_REG_CTRL   = 32'h0000_0004;
  localparam logic [DEFAULT_ADDR_WIDTH-1:0] UART_REG_STATUS = 32'h0000_0008;
  localparam logic [DEFAULT_ADDR_WIDTH-1:0] UART_REG_BAUD   = 32'h0000_000C;
  localparam logic [DEFAULT_ADDR_WIDTH-1:0] UART_REG_RXDATA = 32'h0000_0010;

endpackage

// File: rtl/apb_uart_master.sv
// APB initiator: turns one valid/ready command into one APB transfer and returns a response.
// Handshakes: a beat transfers on the rising edge where valid and ready are both high; valid holds its payload until then.
module apb_uart_master
  import apb_uart_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic                  rsp_timeout,
  output logic                  PSELx,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR,
  output logic [1:0]            state_o
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  apb_state_e            state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  psel_q;
  logic                  penable_q;
  logic                  pwrite_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  rsp_error_q;
  logic                  rsp_timeout_q;
  logic                  timeout_hit;

  generate
    if (TIMEOUT_CYCLES != 0) begin : g_timeout
      assign timeout_hit = (cnt_q == CNT_LAST);
    end else begin : g_no_timeout
      assign timeout_hit = 1'b0;
    end
  endgenerate

  assign cmd_ready = PRESETn && (state_q == IDLE) && !rsp_valid_q;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_error_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      if (rsp_valid_q && rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            paddr_q   <= cmd_addr;
            pwrite_q  <= cmd_write;
            pwdata_q  <= cmd_write ? cmd_wdata : '0;
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            state_q   <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          cnt_q     <= '0;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          // PREADY takes priority over an expiring timeout
          if (PREADY) begin
            rsp_rdata_q   <= pwrite_q ? '0 : PRDATA;
            rsp_error_q   <= PSLVERR;
            rsp_timeout_q <= 1'b0;
            rsp_valid_q   <= 1'b1;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            state_q       <= IDLE;
          end else if (timeout_hit) begin
            rsp_rdata_q   <= '0;
            rsp_error_q   <= 1'b1;
            rsp_timeout_q <= 1'b1;
            rsp_valid_q   <= 1'b1;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            state_q       <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign PSELx       = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_error   = rsp_error_q;
  assign rsp_timeout = rsp_timeout_q;
  assign state_o     = state_q;

endmodule

// File: doc/apb_uart_master.md
Name: apb_uart_master

Overview:
- APB initiator that drives the APB slave port of the UART subsystem (PSELx/PENABLE/PWRITE/PADDR/PWDATA) from a simple valid/ready command channel.
- Returns read data and status on a valid/ready response channel.
- Used by the system-level testbench/SoC glue and by the loopback integration top to program UART config registers and move TX/RX bytes.
- Handles slave wait states and PSLVERR, and aborts transfers on a PREADY timeout.

Parameters:
- DATA_WIDTH, 32, APB data width; matches the UART slave data width.
- ADDR_WIDTH, 32, APB address width; matches the UART slave address width.
- TIMEOUT_CYCLES, 64, maximum ACCESS cycles with PREADY low before abort; 0 disables the timeout.

Ports:
- PCLK  in  1  APB clock; all logic is on its rising edge.
- PRESETn  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  target address.
- cmd_wdata  in  DATA_WIDTH  write data; ignored for reads.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when high together with rsp_valid.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and for timeouts.
- rsp_error  out  1  PSLVERR was seen, or timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- PSELx  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  ADDR_WIDTH  APB address.
- PWDATA  out  DATA_WIDTH  APB write data.
- PRDATA  in  DATA_WIDTH  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB error.

Behaviour:
- Reset (async assert, sync deassert handled upstream): state=IDLE. PSELx, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_error, rsp_timeout all 0. cmd_ready=0 while PRESETn low.
- FSM states IDLE, SETUP, ACCESS. All outputs are registered except cmd_ready.
- cmd_ready = (state==IDLE) && !rsp_valid. Only one transfer is outstanding at a time.
- IDLE: on cmd_valid&&cmd_ready at edge N:
  - latch PADDR, PWRITE and PWDATA (PWDATA=0 for reads);
  - PSELx=1, PENABLE=0 from cycle N+1;
  - state=SETUP.
- SETUP: unconditionally go to ACCESS next edge; PENABLE=1; clear the timeout counter.
- ACCESS: PADDR, PWRITE, PWDATA, PSELx and PENABLE held stable.
  - If PREADY=1 at an edge: capture rsp_rdata (PRDATA for reads, 0 for writes) and rsp_error=PSLVERR. Set rsp_timeout=0 and rsp_valid=1. Drop PSELx/PENABLE. Go to IDLE.
  - If PREADY=0: increment the counter.
  - If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1 with PREADY still 0: abort. Drop PSELx/PENABLE, rsp_error=1, rsp_timeout=1, rsp_rdata=0, rsp_valid=1, go to IDLE.
- Minimum latency: command accept at N, SETUP N+1, ACCESS N+2, rsp_valid visible at N+3 with zero wait states.
- PREADY and timeout in the same cycle: PREADY wins, so the response is normal.
- PADDR/PWRITE/PWDATA keep their last values in IDLE. PSELx=0 means they carry no meaning.
- Response register: rsp_valid stays high, with payload stable, until rsp_ready. It clears on the edge where rsp_valid&&rsp_ready. A new command can be accepted on the cycle after that clear.
- PSLVERR is sampled only in ACCESS with PREADY=1; it is ignored otherwise.
- Reset mid-transfer (any state): outputs return to their reset values immediately, the transfer is dropped and no response is produced.
- Timeout counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1. It is unused when TIMEOUT_CYCLES=0, and ACCESS then waits indefinitely.

Decomposition:
- Shared package apb_uart_pkg holds:
  - the state enum (IDLE, SETUP, ACCESS);
  - default DATA_WIDTH/ADDR_WIDTH constants;
  - a packed apb_cmd_t {write, addr, wdata} and an apb_rsp_t {rdata, error, timeout};
  - UART register offset constants used by the bench.
- No sub-module. The FSM, timeout counter and response register live in one module.

Test Plan:
- Write 0x0000_00A5 to addr 0x04 with PREADY tied 1:
  - PSELx rises at N+1, PENABLE at N+2;
  - PWDATA=0xA5 stable through both cycles;
  - rsp_valid at N+3 with rsp_error=0 and rsp_rdata=0.
- Read addr 0x08, slave inserts 3 wait states, PRDATA=0x0000_005C: PENABLE stays high for 4 cycles, then rsp_rdata=0x5C.
- Write with PSLVERR=1 on the PREADY cycle: rsp_error=1, rsp_timeout=0.
- TIMEOUT_CYCLES=16, PREADY held 0: PSELx drops after 16 ACCESS cycles, and the response has error=1, timeout=1, rdata=0.
- rsp_ready held 0 for 10 cycles after a response: cmd_ready stays 0 and the payload is stable. cmd_ready rises the cycle after the handshake.
- PRESETn pulsed low during ACCESS: PSELx/PENABLE go to 0 asynchronously, no rsp_valid is produced, and the next command completes normally.
